// File: rtl/complex_adder_issuer.sv
// Operand FIFO and handshake sequencer that feeds a double-precision complex adder.
// Each buffered pair goes out on four stb/ack channels, the two sum halves come back on
// two stb/ack channels, and the captured sum is offered on a valid/ready port.
// Only one pair is in flight at a time.
module complex_adder_issuer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [W-1:0]               in_a_real,
    input  logic [W-1:0]               in_a_imag,
    input  logic [W-1:0]               in_b_real,
    input  logic [W-1:0]               in_b_imag,
    output logic [W-1:0]               input_a_real,
    output logic [W-1:0]               input_a_imag,
    output logic [W-1:0]               input_b_real,
    output logic [W-1:0]               input_b_imag,
    output logic                       input_a_real_stb,
    output logic                       input_a_imag_stb,
    output logic                       input_b_real_stb,
    output logic                       input_b_imag_stb,
    input  logic                       input_a_real_ack,
    input  logic                       input_a_imag_ack,
    input  logic                       input_b_real_ack,
    input  logic                       input_b_imag_ack,
    input  logic [W-1:0]               output_z_real,
    input  logic [W-1:0]               output_z_imag,
    input  logic                       output_z_real_stb,
    input  logic                       output_z_imag_stb,
    output logic                       output_z_real_ack,
    output logic                       output_z_imag_ack,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [W-1:0]               res_real,
    output logic [W-1:0]               res_imag,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitZ, StHold} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [4*W-1:0]  mem [DEPTH];
    // Operand word layout: {b_imag, b_real, a_imag, a_real}; bit i of stb/sent/ack is channel i
    logic [4*W-1:0]  op_q, op_d;
    logic [3:0]      stb_q, stb_d;
    logic [3:0]      sent_q, sent_d;
    logic [1:0]      got_q, got_d;
    logic [1:0]      zack_q, zack_d;
    logic            res_valid_q, res_valid_d;
    logic [W-1:0]    res_real_q, res_real_d;
    logic [W-1:0]    res_imag_q, res_imag_d;
    logic [3:0]      ack;
    logic [4*W-1:0]  head;
    logic            push, pop;

    assign ack      = {input_b_imag_ack, input_b_real_ack, input_a_imag_ack, input_a_real_ack};
    assign head     = mem[rd_ptr_q];
    // Full is judged on the registered count alone, so a same-cycle pop never frees a slot
    assign in_ready = (count_q < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign count_d  = count_q + CW'(push) - CW'(pop);

    // FIFO storage; no reset needed since occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {in_b_imag, in_b_real, in_a_imag, in_a_real};
        end
    end

    // Next-state and datapath decisions for the issue/collect sequence
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        stb_d       = stb_q;
        sent_d      = sent_q;
        got_d       = got_q;
        zack_d      = 2'b00;
        res_valid_d = res_valid_q;
        res_real_d  = res_real_q;
        res_imag_d  = res_imag_q;
        pop         = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    op_d    = head;
                    stb_d   = 4'hF;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                for (int i = 0; i < 4; i++) begin
                    if (stb_q[i] && ack[i]) begin
                        stb_d[i]  = 1'b0;
                        sent_d[i] = 1'b1;
                    end
                end
                // The head stays in the FIFO until every channel has been accepted
                if (&sent_q) begin
                    pop     = 1'b1;
                    sent_d  = 4'h0;
                    state_d = StWaitZ;
                end
            end
            StWaitZ: begin
                if (output_z_real_stb && !got_q[0]) begin
                    res_real_d = output_z_real;
                    got_d[0]   = 1'b1;
                    zack_d[0]  = 1'b1;
                end
                if (output_z_imag_stb && !got_q[1]) begin
                    res_imag_d = output_z_imag;
                    got_d[1]   = 1'b1;
                    zack_d[1]  = 1'b1;
                end
                if (&got_q) begin
                    res_valid_d = 1'b1;
                    state_d     = StHold;
                end
            end
            StHold: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    got_d       = 2'b00;
                    if (count_q != '0) begin
                        op_d    = head;
                        stb_d   = 4'hF;
                        state_d = StIssue;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, pointer and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            op_q        <= '0;
            stb_q       <= 4'h0;
            sent_q      <= 4'h0;
            got_q       <= 2'b00;
            zack_q      <= 2'b00;
            res_valid_q <= 1'b0;
            res_real_q  <= '0;
            res_imag_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= push ? wr_ptr_q + AW'(1) : wr_ptr_q;
            rd_ptr_q    <= pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
            count_q     <= count_d;
            op_q        <= op_d;
            stb_q       <= stb_d;
            sent_q      <= sent_d;
            got_q       <= got_d;
            zack_q      <= zack_d;
            res_valid_q <= res_valid_d;
            res_real_q  <= res_real_d;
            res_imag_q  <= res_imag_d;
        end
    end

    assign input_a_real      = op_q[W-1:0];
    assign input_a_imag      = op_q[2*W-1:W];
    assign input_b_real      = op_q[3*W-1:2*W];
    assign input_b_imag      = op_q[4*W-1:3*W];
    assign input_a_real_stb  = stb_q[0];
    assign input_a_imag_stb  = stb_q[1];
    assign input_b_real_stb  = stb_q[2];
    assign input_b_imag_stb  = stb_q[3];
    assign output_z_real_ack = zack_q[0];
    assign output_z_imag_ack = zack_q[1];
    assign res_valid         = res_valid_q;
    assign res_real          = res_real_q;
    assign res_imag          = res_imag_q;
    assign count             = count_q;
    assign busy              = (state_q != StIdle);

endmodule
